// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select codes and hazard FSM states.
// Imported by the interface, the per-source selector and the top.
package forwarding_hazard_unit_pkg;

   localparam logic [1:0] FWD_RF     = 2'b00;
   localparam logic [1:0] FWD_MEM_WB = 2'b01;
   localparam logic [1:0] FWD_EX_MEM = 2'b10;
   localparam logic [1:0] FWD_ID_EX  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_ERROR    = 2'b10
   } state_t;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// Bundle between the pipeline datapath (master) and the forwarding/hazard unit (slave).
// All signals are level-sensitive per cycle; there is no valid/ready handshake on this bus.
interface forwarding_hazard_unit_if
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int RBITS = 5,
   parameter int FBITS = 2,
   parameter int NSRC  = 2,
   parameter int CBITS = 16
);
   logic [NSRC*RBITS-1:0] ID_src;
   logic [NSRC-1:0]       ID_src_used;
   logic [RBITS-1:0]      ID_EX_rd;
   logic [RBITS-1:0]      EX_MEM_rd;
   logic [RBITS-1:0]      MEM_WB_rd;
   logic                  ID_EX_regwrite;
   logic                  EX_MEM_regwrite;
   logic                  MEM_WB_regwrite;
   logic                  ID_EX_memread;
   logic                  EX_MEM_memread;
   logic                  EX_MEM_memwrite;
   logic                  dmem_ready;
   logic                  flush;
   logic                  cnt_clear;

   logic [NSRC*FBITS-1:0] forward;
   logic                  pc_hold;
   logic                  if_id_hold;
   logic                  id_ex_bubble;
   logic                  pipe_freeze;
   logic                  mem_err;
   logic [CBITS-1:0]      stall_cnt;
   state_t                fsm_state;

   modport master (
      output ID_src, ID_src_used, ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
             ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite,
             ID_EX_memread, EX_MEM_memread, EX_MEM_memwrite,
             dmem_ready, flush, cnt_clear,
      input  forward, pc_hold, if_id_hold, id_ex_bubble, pipe_freeze,
             mem_err, stall_cnt, fsm_state
   );

   modport slave (
      input  ID_src, ID_src_used, ID_EX_rd, EX_MEM_rd, MEM_WB_rd,
             ID_EX_regwrite, EX_MEM_regwrite, MEM_WB_regwrite,
             ID_EX_memread, EX_MEM_memread, EX_MEM_memwrite,
             dmem_ready, flush, cnt_clear,
      output forward, pc_hold, if_id_hold, id_ex_bubble, pipe_freeze,
             mem_err, stall_cnt, fsm_state
   );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// Forward-source selection and load-use detection for one ID-stage source operand.
// Purely combinational; the youngest matching stage wins.
module fwd_select
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int RBITS = 5,
   parameter int FBITS = 2
) (
   input  logic [RBITS-1:0] src,
   input  logic             src_used,
   input  logic [RBITS-1:0] id_ex_rd,
   input  logic             id_ex_regwrite,
   input  logic             id_ex_memread,
   input  logic [RBITS-1:0] ex_mem_rd,
   input  logic             ex_mem_regwrite,
   input  logic             ex_mem_memread,
   input  logic [RBITS-1:0] mem_wb_rd,
   input  logic             mem_wb_regwrite,
   output logic [FBITS-1:0] fwd,
   output logic             load_use
);

   logic src_nz;
   logic hit_id_ex;
   logic hit_ex_mem;
   logic hit_mem_wb;

   always_comb begin
      src_nz     = (src != '0);
      hit_id_ex  = id_ex_regwrite  && (id_ex_rd  == src) && src_nz;
      hit_ex_mem = ex_mem_regwrite && (ex_mem_rd == src) && src_nz;
      hit_mem_wb = mem_wb_regwrite && (mem_wb_rd == src) && src_nz;

      fwd      = FBITS'(FWD_RF);
      load_use = 1'b0;
      if (hit_id_ex) begin
         fwd      = FBITS'(FWD_ID_EX);
         load_use = src_used && id_ex_memread;
      end else if (hit_ex_mem) begin
         fwd      = FBITS'(FWD_EX_MEM);
         load_use = src_used && ex_mem_memread;
      end else if (hit_mem_wb) begin
         fwd      = FBITS'(FWD_MEM_WB);
      end
   end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Pipeline forwarding and hazard control: per-source forward selects, load-use stall,
// data-memory wait freeze with timeout, and a saturating stall-cycle counter.
module forwarding_hazard_unit
   import forwarding_hazard_unit_pkg::*;
#(
   parameter int RBITS   = 5,
   parameter int FBITS   = 2,
   parameter int NSRC    = 2,
   parameter int CBITS   = 16,
   parameter int TIMEOUT = 64
) (
   input logic clk,
   input logic rst_n,
   forwarding_hazard_unit_if.slave bus
);

   localparam int WBITS = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [WBITS-1:0] WAIT_LAST = WBITS'(TIMEOUT - 1);

   logic [NSRC*FBITS-1:0] fwd_all;
   logic [NSRC-1:0]       load_k;
   logic                  hazard;

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      fwd_select #(.RBITS(RBITS), .FBITS(FBITS)) u_fwd_select (
         .src             (bus.ID_src[k*RBITS +: RBITS]),
         .src_used        (bus.ID_src_used[k]),
         .id_ex_rd        (bus.ID_EX_rd),
         .id_ex_regwrite  (bus.ID_EX_regwrite),
         .id_ex_memread   (bus.ID_EX_memread),
         .ex_mem_rd       (bus.EX_MEM_rd),
         .ex_mem_regwrite (bus.EX_MEM_regwrite),
         .ex_mem_memread  (bus.EX_MEM_memread),
         .mem_wb_rd       (bus.MEM_WB_rd),
         .mem_wb_regwrite (bus.MEM_WB_regwrite),
         .fwd             (fwd_all[k*FBITS +: FBITS]),
         .load_use        (load_k[k])
      );
   end

   state_t           state_q, state_d;
   logic [WBITS-1:0] wait_q, wait_d;
   logic [CBITS-1:0] stall_cnt_q, stall_cnt_d;
   logic             mem_access;
   logic             freeze;
   logic             pc_hold;
   logic             if_id_hold;
   logic             id_ex_bubble;

   always_comb begin
      hazard     = |load_k;
      mem_access = bus.EX_MEM_memread | bus.EX_MEM_memwrite;
      state_d    = state_q;
      wait_d     = wait_q;
      freeze     = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            if (mem_access && !bus.dmem_ready) begin
               freeze  = 1'b1;
               state_d = ST_MEM_WAIT;
               wait_d  = '0;
            end
         end
         ST_MEM_WAIT: begin
            if (bus.dmem_ready) begin
               state_d = ST_RUN;
            end else begin
               freeze = 1'b1;
               if (wait_q == WAIT_LAST) begin
                  state_d = ST_ERROR;
               end else begin
                  wait_d = wait_q + 1'b1;
               end
            end
         end
         ST_ERROR: begin
            freeze = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // Priority: freeze, then flush (kills the instruction, so its hazard is moot), then load-use.
   always_comb begin
      pc_hold      = 1'b0;
      if_id_hold   = 1'b0;
      id_ex_bubble = 1'b0;
      if (freeze) begin
         pc_hold    = 1'b1;
         if_id_hold = 1'b1;
      end else if (bus.flush) begin
         id_ex_bubble = 1'b1;
      end else if (hazard) begin
         pc_hold      = 1'b1;
         if_id_hold   = 1'b1;
         id_ex_bubble = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (bus.cnt_clear) begin
         stall_cnt_d = '0;
      end else if (pc_hold && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_q      <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.forward      = fwd_all;
   assign bus.pc_hold      = pc_hold;
   assign bus.if_id_hold   = if_id_hold;
   assign bus.id_ex_bubble = id_ex_bubble;
   assign bus.pipe_freeze  = freeze;
   assign bus.mem_err      = (state_q == ST_ERROR);
   assign bus.stall_cnt    = stall_cnt_q;
   assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench: instance A uses default parameters, instance B uses TIMEOUT=4, CBITS=4.
module tb_forwarding_hazard_unit;
   import forwarding_hazard_unit_pkg::*;

   logic clk;
   logic rst_n_a;
   logic rst_n_b;
   int   checks;
   int   failures;
   int   n;

   forwarding_hazard_unit_if #(.RBITS(5), .FBITS(2), .NSRC(2), .CBITS(16)) if_a ();
   forwarding_hazard_unit_if #(.RBITS(5), .FBITS(2), .NSRC(2), .CBITS(4))  if_b ();

   forwarding_hazard_unit #(.RBITS(5), .FBITS(2), .NSRC(2), .CBITS(16), .TIMEOUT(64)) dut_a (
      .clk   (clk),
      .rst_n (rst_n_a),
      .bus   (if_a)
   );

   forwarding_hazard_unit #(.RBITS(5), .FBITS(2), .NSRC(2), .CBITS(4), .TIMEOUT(4)) dut_b (
      .clk   (clk),
      .rst_n (rst_n_b),
      .bus   (if_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_a();
      if_a.ID_src          = '0;
      if_a.ID_src_used     = '0;
      if_a.ID_EX_rd        = '0;
      if_a.EX_MEM_rd       = '0;
      if_a.MEM_WB_rd       = '0;
      if_a.ID_EX_regwrite  = 1'b0;
      if_a.EX_MEM_regwrite = 1'b0;
      if_a.MEM_WB_regwrite = 1'b0;
      if_a.ID_EX_memread   = 1'b0;
      if_a.EX_MEM_memread  = 1'b0;
      if_a.EX_MEM_memwrite = 1'b0;
      if_a.dmem_ready      = 1'b0;
      if_a.flush           = 1'b0;
      if_a.cnt_clear       = 1'b0;
   endtask

   task automatic clear_b();
      if_b.ID_src          = '0;
      if_b.ID_src_used     = '0;
      if_b.ID_EX_rd        = '0;
      if_b.EX_MEM_rd       = '0;
      if_b.MEM_WB_rd       = '0;
      if_b.ID_EX_regwrite  = 1'b0;
      if_b.EX_MEM_regwrite = 1'b0;
      if_b.MEM_WB_regwrite = 1'b0;
      if_b.ID_EX_memread   = 1'b0;
      if_b.EX_MEM_memread  = 1'b0;
      if_b.EX_MEM_memwrite = 1'b0;
      if_b.dmem_ready      = 1'b0;
      if_b.flush           = 1'b0;
      if_b.cnt_clear       = 1'b0;
   endtask

   task automatic b_mem_episode(input string tag);
      if_b.EX_MEM_memwrite = 1'b1;
      if_b.dmem_ready      = 1'b0;
      repeat (4) @(negedge clk);
      check({tag, "_state_wait"}, 32'(if_b.fsm_state), 32'(ST_MEM_WAIT));
      check({tag, "_no_err"}, 32'(if_b.mem_err), 32'd0);
      if_b.dmem_ready = 1'b1;
      #1;
      check({tag, "_ready_unfreeze"}, 32'(if_b.pipe_freeze), 32'd0);
      @(negedge clk);
      check({tag, "_back_run"}, 32'(if_b.fsm_state), 32'(ST_RUN));
      if_b.EX_MEM_memwrite = 1'b0;
      if_b.dmem_ready      = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n_a  = 1'b0;
      rst_n_b  = 1'b0;
      clear_a();
      clear_b();

      // Reset values and combinational behaviour while held in reset
      @(negedge clk);
      check("rst_forward", 32'(if_a.forward), 32'd0);
      check("rst_pc_hold", 32'(if_a.pc_hold), 32'd0);
      check("rst_stall_cnt", 32'(if_a.stall_cnt), 32'd0);
      check("rst_mem_err", 32'(if_a.mem_err), 32'd0);
      check("rst_state", 32'(if_a.fsm_state), 32'(ST_RUN));
      if_a.ID_src         = {5'd0, 5'd3};
      if_a.ID_src_used    = 2'b01;
      if_a.ID_EX_rd       = 5'd3;
      if_a.ID_EX_regwrite = 1'b1;
      if_a.ID_EX_memread  = 1'b1;
      #1;
      check("rst_hazard_pc_hold", 32'(if_a.pc_hold), 32'd1);
      check("rst_hazard_fwd", 32'(if_a.forward), 32'h3);
      @(posedge clk);
      #1;
      check("rst_cnt_held", 32'(if_a.stall_cnt), 32'd0);
      clear_a();
      rst_n_a = 1'b1;
      rst_n_b = 1'b1;

      // All stages write r2: youngest (ID_EX) wins, then priority falls back
      @(negedge clk);
      if_a.ID_src          = {5'd0, 5'd2};
      if_a.ID_src_used     = 2'b01;
      if_a.ID_EX_rd        = 5'd2;
      if_a.EX_MEM_rd       = 5'd2;
      if_a.MEM_WB_rd       = 5'd2;
      if_a.ID_EX_regwrite  = 1'b1;
      if_a.EX_MEM_regwrite = 1'b1;
      if_a.MEM_WB_regwrite = 1'b1;
      #1;
      check("fwd0_id_ex", 32'(if_a.forward[1:0]), 32'h3);
      check("fwd1_r0", 32'(if_a.forward[3:2]), 32'h0);
      check("no_stall_pc", 32'(if_a.pc_hold), 32'd0);
      check("no_stall_bubble", 32'(if_a.id_ex_bubble), 32'd0);
      if_a.ID_EX_regwrite = 1'b0;
      #1;
      check("fwd0_ex_mem", 32'(if_a.forward[1:0]), 32'h2);
      if_a.EX_MEM_regwrite = 1'b0;
      #1;
      check("fwd0_mem_wb", 32'(if_a.forward[1:0]), 32'h1);
      if_a.MEM_WB_regwrite = 1'b0;
      #1;
      check("fwd0_rf", 32'(if_a.forward[1:0]), 32'h0);
      if_a.ID_src = {5'd0, 5'd7};
      if_a.ID_EX_rd = 5'd6;
      if_a.ID_EX_regwrite = 1'b1;
      #1;
      check("fwd0_rd_mismatch", 32'(if_a.forward[1:0]), 32'h0);

      // Register 0 never forwards and never stalls, even with loads in flight
      clear_a();
      if_a.ID_src_used     = 2'b11;
      if_a.ID_EX_regwrite  = 1'b1;
      if_a.EX_MEM_regwrite = 1'b1;
      if_a.MEM_WB_regwrite = 1'b1;
      if_a.ID_EX_memread   = 1'b1;
      #1;
      check("r0_forward", 32'(if_a.forward), 32'h0);
      check("r0_no_stall", 32'(if_a.pc_hold), 32'd0);

      // Load-use on ID_EX, then flush overriding it, then unused source
      clear_a();
      if_a.ID_src         = {5'd0, 5'd3};
      if_a.ID_src_used    = 2'b01;
      if_a.ID_EX_rd       = 5'd3;
      if_a.ID_EX_regwrite = 1'b1;
      if_a.ID_EX_memread  = 1'b1;
      #1;
      check("lu_pc_hold", 32'(if_a.pc_hold), 32'd1);
      check("lu_if_id_hold", 32'(if_a.if_id_hold), 32'd1);
      check("lu_bubble", 32'(if_a.id_ex_bubble), 32'd1);
      if_a.flush = 1'b1;
      #1;
      check("flush_bubble", 32'(if_a.id_ex_bubble), 32'd1);
      check("flush_pc_hold", 32'(if_a.pc_hold), 32'd0);
      check("flush_if_id_hold", 32'(if_a.if_id_hold), 32'd0);
      if_a.flush       = 1'b0;
      if_a.ID_src_used = 2'b00;
      #1;
      check("unused_no_hazard", 32'(if_a.pc_hold), 32'd0);

      // Load-use on EX_MEM for source 1; shadowed when ID_EX also writes r4 without loading
      clear_a();
      if_a.ID_src          = {5'd4, 5'd0};
      if_a.ID_src_used     = 2'b10;
      if_a.EX_MEM_rd       = 5'd4;
      if_a.EX_MEM_regwrite = 1'b1;
      if_a.EX_MEM_memread  = 1'b1;
      if_a.dmem_ready      = 1'b1;
      #1;
      check("exm_lu_fwd1", 32'(if_a.forward[3:2]), 32'h2);
      check("exm_lu_pc_hold", 32'(if_a.pc_hold), 32'd1);
      if_a.ID_EX_rd       = 5'd4;
      if_a.ID_EX_regwrite = 1'b1;
      #1;
      check("shadow_fwd1", 32'(if_a.forward[3:2]), 32'h3);
      check("shadow_no_hazard", 32'(if_a.pc_hold), 32'd0);

      // Zero the counter before the memory-wait sequence
      clear_a();
      if_a.cnt_clear = 1'b1;
      @(negedge clk);
      if_a.cnt_clear = 1'b0;
      #1;
      check("cnt_cleared", 32'(if_a.stall_cnt), 32'd0);

      // EX_MEM load with dmem_ready low for 5 edges; a pending load-use must not bubble
      if_a.EX_MEM_memread = 1'b1;
      if_a.dmem_ready     = 1'b0;
      if_a.ID_src         = {5'd0, 5'd3};
      if_a.ID_src_used    = 2'b01;
      if_a.ID_EX_rd       = 5'd3;
      if_a.ID_EX_regwrite = 1'b1;
      if_a.ID_EX_memread  = 1'b1;
      #1;
      check("frz_c1_freeze", 32'(if_a.pipe_freeze), 32'd1);
      check("frz_c1_bubble", 32'(if_a.id_ex_bubble), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("frz_freeze", 32'(if_a.pipe_freeze), 32'd1);
         check("frz_pc_hold", 32'(if_a.pc_hold), 32'd1);
         check("frz_bubble", 32'(if_a.id_ex_bubble), 32'd0);
      end
      check("frz_state", 32'(if_a.fsm_state), 32'(ST_MEM_WAIT));
      @(negedge clk);
      if_a.dmem_ready     = 1'b1;
      if_a.ID_src_used    = 2'b00;
      #1;
      check("frz_release", 32'(if_a.pipe_freeze), 32'd0);
      check("frz_release_pc", 32'(if_a.pc_hold), 32'd0);
      check("frz_stall_cnt", 32'(if_a.stall_cnt), 32'd5);
      @(negedge clk);
      check("frz_back_run", 32'(if_a.fsm_state), 32'(ST_RUN));
      check("frz_ready_no_freeze", 32'(if_a.pipe_freeze), 32'd0);
      check("frz_cnt_stable", 32'(if_a.stall_cnt), 32'd5);
      clear_a();

      // Instance B: two wait episodes ending on the last safe cycle (counter reloads on entry)
      @(negedge clk);
      b_mem_episode("ep1");
      b_mem_episode("ep2");

      // Timeout into ERROR, sticky until reset
      if_b.EX_MEM_memwrite = 1'b1;
      if_b.dmem_ready      = 1'b0;
      n = 0;
      while (!if_b.mem_err && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("to_edges", 32'(n), 32'd5);
      check("to_mem_err", 32'(if_b.mem_err), 32'd1);
      if_b.EX_MEM_memwrite = 1'b0;
      if_b.dmem_ready      = 1'b1;
      repeat (2) @(negedge clk);
      check("err_sticky", 32'(if_b.mem_err), 32'd1);
      check("err_freeze", 32'(if_b.pipe_freeze), 32'd1);
      check("err_pc_hold", 32'(if_b.pc_hold), 32'd1);
      check("err_state", 32'(if_b.fsm_state), 32'(ST_ERROR));
      #2;
      rst_n_b = 1'b0;
      #1;
      check("arst_mem_err", 32'(if_b.mem_err), 32'd0);
      check("arst_state", 32'(if_b.fsm_state), 32'(ST_RUN));
      check("arst_freeze", 32'(if_b.pipe_freeze), 32'd0);
      check("arst_cnt", 32'(if_b.stall_cnt), 32'd0);
      #1;
      rst_n_b = 1'b1;
      @(negedge clk);
      check("post_rst_run", 32'(if_b.fsm_state), 32'(ST_RUN));
      check("post_rst_err", 32'(if_b.mem_err), 32'd0);

      // Saturation of the 4-bit counter over 20 stall cycles, then clear during stall
      clear_b();
      if_b.ID_src         = {5'd0, 5'd3};
      if_b.ID_src_used    = 2'b01;
      if_b.ID_EX_rd       = 5'd3;
      if_b.ID_EX_regwrite = 1'b1;
      if_b.ID_EX_memread  = 1'b1;
      repeat (20) @(negedge clk);
      check("sat_cnt", 32'(if_b.stall_cnt), 32'd15);
      if_b.cnt_clear = 1'b1;
      #1;
      check("clr_pc_hold", 32'(if_b.pc_hold), 32'd1);
      @(negedge clk);
      check("clr_cnt", 32'(if_b.stall_cnt), 32'd0);
      if_b.cnt_clear = 1'b0;
      @(negedge clk);
      check("clr_then_inc", 32'(if_b.stall_cnt), 32'd1);
      clear_b();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
